// File: rtl/nibble_serial_sub16_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// The producer/consumer side uses the master modport, the subtractor uses slave.
`timescale 1ns/1ps

interface nibble_serial_sub16_if #(
  parameter int WIDTH = 16
);
  // operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  // result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/nibble_serial_sub16.sv
// Nibble-serial subtractor: diff = a - b - bin, one 4-bit slice per clock,
// LSB nibble first. The borrow only travels between nibbles through
// borrow_reg. Results are published into diff_reg/bout_reg/ovf_reg on HOLD
// entry and stay put until the next HOLD entry.
`timescale 1ns/1ps

module nibble_serial_sub16 #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  nibble_serial_sub16_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  // bits of partial result that must be remembered between nibbles
  localparam int SHW = (NIB > 1) ? WIDTH - 4 : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  genvar gi;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             borrow_reg, borrow_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [SHW-1:0]   sh_reg, sh_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic             bout_reg, bout_next;
  logic             ovf_reg, ovf_next;

  logic             in_ready_c;
  logic             out_valid_c;
  logic             accept;
  logic             last_nib;

  logic [3:0]       a_nib [NIB];
  logic [3:0]       b_nib [NIB];
  logic [3:0]       a_k;
  logic [3:0]       b_k;
  logic [3:0]       slice_d;
  logic [4:0]       br;
  logic [WIDTH-1:0] shift_in;
  logic [SHW-1:0]   shift_keep;

  // Nibble views of the latched operands; cnt_reg picks the active one.
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[gi*4 +: 4];
      assign b_nib[gi] = b_reg[gi*4 +: 4];
    end
  endgenerate

  assign a_k = a_nib[cnt_reg];
  assign b_k = b_nib[cnt_reg];

  // The single reusable 4-bit borrow-ripple slice.
  assign br[0] = borrow_reg;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign slice_d[gi] = a_k[gi] ^ b_k[gi] ^ br[gi];
      // borrow out when a_bit < b_bit + borrow_in
      assign br[gi+1]    = (~a_k[gi] & b_k[gi]) | (~(a_k[gi] ^ b_k[gi]) & br[gi]);
    end
  endgenerate

  // New nibble enters at the MSB end; after the last nibble shift_in is the
  // complete difference.
  generate
    if (NIB > 1) begin : g_shift
      assign shift_in   = {slice_d, sh_reg};
      assign shift_keep = shift_in[WIDTH-1:4];
    end else begin : g_noshift
      assign shift_in   = slice_d;
      assign shift_keep = sh_reg;
    end
  endgenerate

  assign last_nib = (cnt_reg == LAST_NIB);
  assign accept   = in_ready_c & bus.in_valid;

  // Next-state and handshake outputs; both handshakes decode from state only.
  always_comb begin
    state_next  = state_reg;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_nib) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath next values: latch on accept, one nibble per RUN cycle,
  // publish the result on the last nibble.
  always_comb begin
    a_next      = a_reg;
    b_next      = b_reg;
    borrow_next = borrow_reg;
    cnt_next    = cnt_reg;
    sh_next     = sh_reg;
    diff_next   = diff_reg;
    bout_next   = bout_reg;
    ovf_next    = ovf_reg;
    if (accept) begin
      a_next      = bus.a;
      b_next      = bus.b;
      borrow_next = bus.bin;
      cnt_next    = '0;
    end else if (state_reg == RUN) begin
      borrow_next = br[4];
      sh_next     = shift_keep;
      cnt_next    = cnt_reg + 1'b1;
      if (last_nib) begin
        diff_next = shift_in;
        bout_next = br[4];
        // signed overflow: operand signs differ and result sign differs from a
        ovf_next  = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                    (shift_in[WIDTH-1] != a_reg[WIDTH-1]);
      end
    end
  end

  // FSM state register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      sh_reg     <= '0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      a_reg      <= a_next;
      b_reg      <= b_next;
      borrow_reg <= borrow_next;
      cnt_reg    <= cnt_next;
      sh_reg     <= sh_next;
      diff_reg   <= diff_next;
      bout_reg   <= bout_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.diff      = diff_reg;
  assign bus.bout      = bout_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// Self-checking bench for nibble_serial_sub16: directed vectors, backpressure,
// asynchronous reset mid-operation and a random back-to-back run checked
// against an arithmetic reference model.
`timescale 1ns/1ps

module tb_nibble_serial_sub16;
  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  vec_t vecs [5] = '{
    '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0},
    '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0},
    '{16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1},
    '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1}
  };

  nibble_serial_sub16_if #(.WIDTH(16)) bus ();

  nibble_serial_sub16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction; ovf from the operand/result signs.
  function automatic logic [17:0] ref_sub(input logic [15:0] a, input logic [15:0] b,
                                          input logic bin);
    int          r;
    logic [15:0] d;
    logic        bo;
    logic        ov;
    r  = int'(a) - int'(b) - int'(bin);
    d  = 16'(r);
    bo = (r < 0);
    ov = (a[15] != b[15]) && (d[15] != a[15]);
    return {bo, ov, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set, wait for out_valid (bounded), report result.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        output logic [15:0] d, output logic bo, output logic ov,
                        output int lat);
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.in_valid = 1'b1;
    total_cnt++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL op_in_ready: got %b expected 1", bus.in_ready);
    else
      pass_cnt++;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    d  = bus.diff;
    bo = bus.bout;
    ov = bus.ovf;
    $display("op %h - %h - %b -> diff=%h bout=%b ovf=%b latency=%0d", a, b, bin, d, bo, ov, lat);
  endtask

  // Take the result and confirm in_ready returns the next cycle.
  task automatic collect();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total_cnt++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL collect_in_ready: got %b expected 1", bus.in_ready);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.diff !== 16'h0000) $display("FAIL reset_diff: got %h expected 0000", bus.diff);
    else pass_cnt++;
    total_cnt++;
    if ({bus.bout, bus.ovf} !== 2'b00) $display("FAIL reset_flags: got %b%b expected 00", bus.bout, bus.ovf);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, ov, lat);
      total_cnt++;
      if (lat !== 4) $display("FAIL dir%0d_latency: got %0d expected 4", i, lat);
      else pass_cnt++;
      total_cnt++;
      if (d !== vecs[i].d) $display("FAIL dir%0d_diff: got %h expected %h", i, d, vecs[i].d);
      else pass_cnt++;
      total_cnt++;
      if (bo !== vecs[i].bo) $display("FAIL dir%0d_bout: got %b expected %b", i, bo, vecs[i].bo);
      else pass_cnt++;
      total_cnt++;
      if (ov !== vecs[i].ov) $display("FAIL dir%0d_ovf: got %b expected %b", i, ov, vecs[i].ov);
      else pass_cnt++;
      collect();
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] exp;
    exp = ref_sub(16'hABCD, 16'h1234, 1'b0);
    bus.a = 16'hABCD;
    bus.b = 16'h1234;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    // RUN: new operands offered, must be ignored
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = i[0];
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      bus.bin = 1'($urandom_range(0, 1));
      total_cnt++;
      if (bus.in_ready !== 1'b0) $display("FAIL bp_run_in_ready: got %b expected 0", bus.in_ready);
      else pass_cnt++;
      tick();
    end
    // HOLD with out_ready low for 6 cycles
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = ~i[0];
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      total_cnt++;
      if (bus.out_valid !== 1'b1) $display("FAIL bp_hold_out_valid: got %b expected 1", bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.diff !== exp[15:0]) $display("FAIL bp_hold_diff: got %h expected %h", bus.diff, exp[15:0]);
      else pass_cnt++;
      total_cnt++;
      if (bus.in_ready !== 1'b0) $display("FAIL bp_hold_in_ready: got %b expected 0", bus.in_ready);
      else pass_cnt++;
      tick();
    end
    $display("op abcd - 1234 - 0 held 6 cycles diff=%h", bus.diff);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL bp_release_out_valid: got %b expected 0", bus.out_valid);
    else pass_cnt++;
    tick();
    // nothing offered during RUN/HOLD may have been taken; result held in IDLE
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_idle_in_ready: got %b expected 1", bus.in_ready);
    else pass_cnt++;
    total_cnt++;
    if ({bus.bout, bus.ovf, bus.diff} !== exp) $display("FAIL bp_idle_hold: got %h expected %h", {bus.bout, bus.ovf, bus.diff}, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          lat;
    bus.a = 16'hFFFF;
    bus.b = 16'h0001;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", bus.in_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.diff !== 16'h0000) $display("FAIL midrst_diff: got %h expected 0000", bus.diff);
    else pass_cnt++;
    #2 rst_n = 1'b1;
    tick();
    run_op(16'h0010, 16'h0001, 1'b0, d, bo, ov, lat);
    total_cnt++;
    if ({bo, ov, d} !== {2'b00, 16'h000F}) $display("FAIL midrst_after: got %b%b_%h expected 00_000f", bo, ov, d);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 4) $display("FAIL midrst_latency: got %0d expected 4", lat);
    else pass_cnt++;
    collect();
  endtask

  task automatic test_back_to_back();
    logic [15:0] qa [$];
    logic [15:0] qb [$];
    logic        qbin [$];
    logic [17:0] exp;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ebin;
    logic        acc_now;
    int          accepted = 0;
    int          done = 0;
    int          last_acc = -1;
    int          cyc = 0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.bin = 1'($urandom_range(0, 1));
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    while ((accepted < 20 || done < 20) && cyc < 400) begin
      acc_now = bus.in_ready & bus.in_valid;
      if (bus.out_valid === 1'b1) begin
        total_cnt++;
        if (qa.size() == 0) begin
          $display("FAIL b2b_spurious: got out_valid=1 expected no pending operation");
        end else begin
          pass_cnt++;
          ea = qa.pop_front();
          eb = qb.pop_front();
          ebin = qbin.pop_front();
          exp = ref_sub(ea, eb, ebin);
          $display("op %h - %h - %b -> diff=%h bout=%b ovf=%b", ea, eb, ebin, bus.diff, bus.bout, bus.ovf);
          total_cnt++;
          if (bus.diff !== exp[15:0]) $display("FAIL b2b_diff: got %h expected %h", bus.diff, exp[15:0]);
          else pass_cnt++;
          total_cnt++;
          if (bus.bout !== exp[17]) $display("FAIL b2b_bout: got %b expected %b", bus.bout, exp[17]);
          else pass_cnt++;
          total_cnt++;
          if (bus.ovf !== exp[16]) $display("FAIL b2b_ovf: got %b expected %b", bus.ovf, exp[16]);
          else pass_cnt++;
          done++;
        end
      end
      if (acc_now) begin
        qa.push_back(bus.a);
        qb.push_back(bus.b);
        qbin.push_back(bus.bin);
        if (last_acc >= 0) begin
          total_cnt++;
          if (cyc - last_acc !== 6) $display("FAIL b2b_interval: got %0d expected 6", cyc - last_acc);
          else pass_cnt++;
        end
        last_acc = cyc;
        accepted++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        if (accepted == 20) begin
          bus.in_valid = 1'b0;
        end else begin
          bus.a = 16'($urandom);
          bus.b = 16'($urandom);
          bus.bin = 1'($urandom_range(0, 1));
        end
      end
    end
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    total_cnt++;
    if (accepted != 20 || done != 20) $display("FAIL b2b_count: got %0d/%0d expected 20/20", accepted, done);
    else pass_cnt++;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1);
  end

endmodule

// File: doc/nibble_serial_sub16.md
# nibble_serial_sub16

Multi-cycle unsigned/two's-complement subtractor computing `diff = a - b - bin`, one 4-bit nibble per clock, LSB first. It is the subtract-direction companion to the team's ripple-carry adder datapath. It reuses a single 4-bit borrow-ripple slice over WIDTH/4 cycles instead of a full-width chain. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

## Interface

**Parameters**
- `WIDTH`, default 16: operand and result width. Must be a multiple of 4 and at least 4.

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: the operand set is presented.
- `in_ready`, output, 1: the block can accept operands.
- `a`, input, WIDTH: minuend.
- `b`, input, WIDTH: subtrahend.
- `bin`, input, 1: borrow-in.
- `out_valid`, output, 1: the result is available.
- `out_ready`, input, 1: the consumer takes the result.
- `diff`, output, WIDTH: `a - b - bin`, modulo 2^WIDTH.
- `bout`, output, 1: borrow-out; 1 when unsigned `a < b + bin`.
- `ovf`, output, 1: signed overflow.

## Operation

- States: IDLE, RUN, HOLD.
- **IDLE**
  - `in_ready` = 1 and `out_valid` = 0.
  - On `in_valid & in_ready`, latch `a`, `b`, `bin` into internal registers, clear the nibble counter, and go to RUN.
- **RUN**
  - `in_ready` = 0 and `out_valid` = 0.
  - Each cycle, subtract nibble k of the latched operands with the running borrow: `{borrow, d} = a_k - b_k - borrow`.
  - Shift `d` into the MSB end of the result shift register. Increment k.
  - After nibble WIDTH/4-1, register the final borrow as `bout`, compute `ovf`, and go to HOLD.
- **HOLD**
  - `out_valid` = 1, and `diff`, `bout`, `ovf` are stable.
  - On `out_ready` = 1, go to IDLE.
  - `in_valid` is ignored while in HOLD.
- **Overflow rule**: `ovf = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1])`, using the latched `a` and `b`. `bin` has no separate term in this rule.
- **Borrow chain**: the initial borrow is the latched `bin`. The borrow passes between nibbles only through the borrow register, never combinationally across cycles.
- **Input changes**: inputs changing after acceptance do not affect the result in progress.
- **Reset** (asynchronous, any state, including mid-RUN): go to IDLE and abort the operation in flight.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `diff`, `bout`, `ovf` = 0.
  - Nibble counter, borrow, and operand registers = 0.
- **Result hold**: `diff`, `bout`, `ovf` keep their last values in IDLE until the next HOLD entry overwrites them.

## Timing

- **Acceptance**: at edge E0, where `in_valid` and `in_ready` are both high.
- **RUN**: occupies edges E1 through E(WIDTH/4). Nibble k is processed at edge E(k+1).
- **Result**: `out_valid` rises after edge E(WIDTH/4). Latency from acceptance to `out_valid` is WIDTH/4 cycles, which is 4 for the default.
- **Result transfer**: at the first edge in HOLD where `out_ready` = 1. `in_ready` rises after that edge.
- **Throughput**: minimum issue interval is WIDTH/4 + 2 cycles, with `out_ready` held high.
- **Backpressure**: `out_valid` stays high indefinitely while `out_ready` = 0, and the outputs do not change.
- **Handshake independence**: `in_ready` does not depend combinationally on `out_ready`, and `out_valid` does not depend combinationally on `in_valid`.
- **Reset release**: the first acceptance is possible at the first rising edge after `rst_n` deasserts.

## Test plan

- `a`=0x0005, `b`=0x0003, `bin`=0 -> `diff`=0x0002, `bout`=0, `ovf`=0. `out_valid` is asserted exactly 4 cycles after acceptance.
- `a`=0x0000, `b`=0x0001, `bin`=0 -> `diff`=0xFFFF, `bout`=1, `ovf`=0. Then `a`=0x1234, `b`=0x1233, `bin`=1 -> `diff`=0x0000, `bout`=0. This exercises the full borrow ripple through all nibbles.
- `a`=0x8000, `b`=0x0001, `bin`=0 -> `diff`=0x7FFF, `bout`=0, `ovf`=1. Then `a`=0x7FFF, `b`=0xFFFF -> `diff`=0x8000, `bout`=1, `ovf`=1.
- Backpressure:
  - Hold `out_ready`=0 for 6 cycles in HOLD; `out_valid` stays 1 and `diff` stays constant.
  - Toggle `in_valid` with new operands during RUN and HOLD; they are not accepted, and `in_ready`=0 throughout.
  - Raise `out_ready`; `in_ready` = 1 on the next cycle.
- Reset mid-RUN: assert `rst_n`=0 after nibble 1 of 0xFFFF - 0x0001.
  - Immediately, without waiting for a clock edge: `out_valid`=0, `in_ready`=1, `diff`=0.
  - After release, 0x0010 - 0x0001 -> 0x000F with no residue from the aborted operation.
- Back-to-back: 20 random operand sets with `in_valid` and `out_ready` held high. Each result equals `(a - b - bin) mod 2^16`, each `bout` matches the reference model, and the issue interval is exactly 6 cycles.
